// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram : 256 x 8 byte-addressed memory with a flip-flop special-register
//       window and an array-backed general-purpose window.
//
//   0x00-0x3F : special registers (flip-flops, cleared by reset)
//   0x40-0xFF : general-purpose storage (array, never cleared)
//
// Ports
//   Clk      in   1  system clock, rising-edge active
//   Rst_n    in   1  synchronous reset, ACTIVE-HIGH despite the name
//   Cs       in   1  chip select; nothing happens unless 1
//   Wen      in   1  write enable (qualified by Cs)
//   Oen      in   1  read enable (qualified by Cs, ignored when Wen=1)
//   Address  in   8  byte address
//   DataIn   in   8  write data
//   DataOut  out  8  registered read data, holds between reads
//   Switches out  8  bit i = bit 0 of register 0x10+i
//   Temp     out  8  contents of register 0x31
// ---------------------------------------------------------------------------
module ram (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Cs,
  input  logic       Wen,
  input  logic       Oen,
  input  logic [7:0] Address,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic [7:0] Switches,
  output logic [7:0] Temp
);

  localparam int unsigned SREG_DEPTH  = 64;
  localparam int unsigned SWITCH_BASE = 16;   // 0x10
  localparam int unsigned TEMP_ADDR   = 49;   // 0x31

  // Special registers live in flip-flops so they can be reset and tapped
  // directly for the Switches / Temp views.
  logic [7:0] r_sreg [0:SREG_DEPTH-1];

  // General-purpose array is indexed by the full address; entries below
  // 0x40 do not exist, so the index range starts at 64.
  logic [7:0] r_gmem [64:255];

  logic [7:0] r_data_out;

  logic       w_wr;
  logic       w_rd;
  logic       w_is_sreg;
  logic [5:0] w_sreg_idx;
  logic [7:0] w_rd_data;

  // Access decode: a write wins over a read when both enables are high.
  always_comb begin
    w_wr       = Cs & Wen;
    w_rd       = Cs & Oen & ~Wen;
    w_is_sreg  = (Address[7:6] == 2'b00);
    w_sreg_idx = Address[5:0];
  end

  // Read-data mux between the two regions.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_is_sreg) begin
      w_rd_data = r_sreg[w_sreg_idx];
    end else begin
      w_rd_data = r_gmem[Address];
    end
  end

  // Special-register file: cleared by reset, which also drops any
  // simultaneous write.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      for (int i = 0; i < SREG_DEPTH; i++) begin
        r_sreg[i] <= 8'h00;
      end
    end else if (w_wr && w_is_sreg) begin
      r_sreg[w_sreg_idx] <= DataIn;
    end
  end

  // General-purpose array: not cleared, but a write coinciding with reset
  // is still discarded so reset has priority everywhere.
  always_ff @(posedge Clk) begin
    if (!Rst_n && w_wr && !w_is_sreg) begin
      r_gmem[Address] <= DataIn;
    end
  end

  // Read-data register: one-cycle latency, holds on every non-read edge.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      r_data_out <= 8'h00;
    end else if (w_rd) begin
      r_data_out <= w_rd_data;
    end
  end

  assign DataOut = r_data_out;

  // Switch bit i is the LSB of register 0x10+i; upper bits stay storage only.
  for (genvar g = 0; g < 8; g++) begin : g_switch
    assign Switches[g] = r_sreg[SWITCH_BASE + g][0];
  end

  assign Temp = r_sreg[TEMP_ADDR];

endmodule

// File: tb/tb_ram.sv
// ---------------------------------------------------------------------------
// tb_ram : self-checking bench for ram. Directed scenarios followed by a
// randomized phase, all compared against a simple array model of the memory.
// ---------------------------------------------------------------------------
module tb_ram;

  logic       Clk;
  logic       Rst_n;
  logic       Cs;
  logic       Wen;
  logic       Oen;
  logic [7:0] Address;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic [7:0] Switches;
  logic [7:0] Temp;

  int errors = 0;
  int checks = 0;

  // Reference model: plain byte array plus the last read value.
  logic [7:0] m_mem [0:255];
  logic [7:0] m_dout;

  ram dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Cs       (Cs),
    .Wen      (Wen),
    .Oen      (Oen),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .Switches (Switches),
    .Temp     (Temp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_switches();
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = m_mem[16 + i][0];
    return s;
  endfunction

  // One clock: drive on the falling edge, update the model at the rising
  // edge, settle 1 time unit afterwards.
  task automatic cyc(input logic rst, input logic cs, input logic wen, input logic oen,
                     input logic [7:0] addr, input logic [7:0] din);
    @(negedge Clk);
    Rst_n = rst; Cs = cs; Wen = wen; Oen = oen; Address = addr; DataIn = din;
    @(posedge Clk);
    if (rst) begin
      m_dout = 8'h00;
      for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    end else if (cs) begin
      if (wen) m_mem[addr] = din;
      else if (oen) m_dout = m_mem[addr];
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00);
  endtask

  initial begin
    Rst_n = 1'b1; Cs = 1'b0; Wen = 1'b0; Oen = 1'b0; Address = 8'h00; DataIn = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_dout = 8'h00;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rst_dout", DataOut, 8'h00);
    check("rst_sw", Switches, 8'h00);
    check("rst_temp", Temp, 8'h00);
    rd(8'h00);
    check("rd_00_after_rst", DataOut, 8'h00);
    rd(8'h3F);
    check("rd_3F_after_rst", DataOut, 8'h00);

    // Full address sweep: write A to A, read it back, check after Cs drops.
    for (int a = 0; a < 256; a++) begin
      wr(8'(a), 8'(a));
      rd(8'(a));
      idle();
      check($sformatf("sweep_%02h", a), DataOut, 8'(a));
    end

    // Switches from LSBs of 0x10-0x17, upper bits still stored.
    wr(8'h10, 8'hA5);
    wr(8'h17, 8'h01);
    for (int a = 8'h11; a <= 8'h16; a++) wr(8'(a), 8'h00);
    idle();
    check("switches_81", Switches, 8'h81);
    rd(8'h10);
    check("rd_10_A5", DataOut, 8'hA5);

    // Temp view and reset leaving the general region intact.
    wr(8'h80, 8'h77);
    wr(8'h31, 8'h3C);
    check("temp_3C", Temp, 8'h3C);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("temp_rst", Temp, 8'h00);
    check("sw_rst", Switches, 8'h00);
    check("dout_rst", DataOut, 8'h00);
    rd(8'h80);
    check("rd_80_kept", DataOut, 8'h77);

    // Reset beats a simultaneous write in both regions.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h55);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h90, 8'h55);
    rd(8'h20);
    check("rst_prio_sreg", DataOut, 8'h00);
    rd(8'h90);
    check("rst_prio_gp", DataOut, 8'h90);

    // Cs=0 ignored, write priority over read.
    rd(8'h40);
    check("rd_40", DataOut, 8'h40);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'hEE);
    check("cs0_hold", DataOut, 8'h40);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 8'h99);
    check("wr_prio_hold", DataOut, 8'h40);
    rd(8'h40);
    check("rd_40_unchanged", DataOut, 8'h40);
    rd(8'h41);
    check("rd_41_99", DataOut, 8'h99);
    wr(8'hFF, 8'h5A);
    rd(8'hFF);
    check("rd_FF", DataOut, 8'h5A);

    // Randomized traffic against the model; every location is known by now.
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst;
      logic [7:0] r_addr;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom);
      cyc(r_rst, 1'($urandom), 1'($urandom), 1'($urandom), r_addr, 8'($urandom));
      check("rand_dout", DataOut, m_dout);
      check("rand_sw", Switches, model_switches());
      check("rand_temp", Temp, m_mem[8'h31]);
    end

    // Final read-back of every location against the model.
    for (int a = 0; a < 256; a++) begin
      rd(8'(a));
      check($sformatf("final_%02h", a), DataOut, m_mem[a]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
